// File: rtl/key_debounce_event_pkg.sv
// Shared definitions for the key debouncer and its ms prescaler: state
// encodings, counter width and the default 1 ms terminal count at 50 MHz.
package key_debounce_event_pkg;

  localparam logic [15:0] T1MS_DEFAULT = 16'd49_999;
  localparam int unsigned MS_W         = 11;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DB_PRESS   = 3'd1,
    S_PRESSED    = 3'd2,
    S_LONG       = 3'd3,
    S_DB_RELEASE = 3'd4
  } state_e;

  // States in which the prescaler and ms counter are allowed to advance.
  function automatic logic state_is_timed(state_e s);
    return (s == S_DB_PRESS) || (s == S_PRESSED) || (s == S_DB_RELEASE);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms prescaler with synchronous clear; tick_o pulses for one
// clock on the T1MS -> 0 wrap.
module ms_tick_gen
  import key_debounce_event_pkg::*;
#(
  parameter logic [15:0] T1MS = T1MS_DEFAULT
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr_i,
  output logic tick_o
);

  logic [15:0] pres_q, pres_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    pres_d = pres_q + 16'd1;
    if (clr_i || (pres_q == T1MS)) begin
      pres_d = '0;
    end
  end

  assign tick_o = !clr_i && (pres_q == T1MS);

  // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pres_q <= '0;
    end else begin
      pres_q <= pres_d;
    end
  end

endmodule

// File: rtl/key_debounce_event.sv
// Debounces an active-low, bouncy push-button and emits registered one-cycle
// press, release and long-press strobes plus the debounced level.
module key_debounce_event
  import key_debounce_event_pkg::*;
#(
  parameter logic [15:0]     T1MS        = T1MS_DEFAULT,
  parameter logic [MS_W-1:0] DEBOUNCE_MS = 11'd10,
  parameter logic [MS_W-1:0] LONG_MS     = 11'd1000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Key_In,
  output logic Press_Sig,
  output logic Release_Sig,
  output logic Long_Sig,
  output logic Key_State
);

  logic [1:0]      sync_q;
  logic            ks;
  state_e          state_q, state_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic            long_done_q, long_done_d;
  logic            key_state_q, key_state_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic            cnt_clr;
  logic            ms_tick;

  assign ks = sync_q[1];

  // Counters restart on every state change and idle outside the timed states.
  assign cnt_clr = (state_d != state_q) || !state_is_timed(state_q);

  ms_tick_gen #(.T1MS(T1MS)) u_ms_tick (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .clr_i  (cnt_clr),
    .tick_o (ms_tick)
  );

  always_comb begin
    state_d     = state_q;
    long_done_d = long_done_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!ks) state_d = S_DB_PRESS;
      end
      S_DB_PRESS: begin
        if (ks) begin
          state_d = S_IDLE;
        end else if (ms_q == DEBOUNCE_MS) begin
          press_d     = 1'b1;
          key_state_d = 1'b1;
          long_done_d = 1'b0;
          state_d     = S_PRESSED;
        end
      end
      S_PRESSED: begin
        // Release is checked first so it beats a coincident long-press.
        if (ks) begin
          state_d = S_DB_RELEASE;
        end else if (ms_q == LONG_MS) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
          state_d     = S_LONG;
        end
      end
      S_LONG: begin
        if (ks) state_d = S_DB_RELEASE;
      end
      S_DB_RELEASE: begin
        if (!ks) begin
          state_d = long_done_q ? S_LONG : S_PRESSED;
        end else if (ms_q == DEBOUNCE_MS) begin
          release_d   = 1'b1;
          key_state_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ms_d = ms_q;
    if (cnt_clr) begin
      ms_d = '0;
    end else if (ms_tick && (ms_q != '1)) begin
      ms_d = ms_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_q      <= 2'b11;
      state_q     <= S_IDLE;
      ms_q        <= '0;
      long_done_q <= 1'b0;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], Key_In};
      state_q     <= state_d;
      ms_q        <= ms_d;
      long_done_q <= long_done_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign Press_Sig   = press_q;
  assign Release_Sig = release_q;
  assign Long_Sig    = long_q;
  assign Key_State   = key_state_q;

endmodule

// File: tb/tb_key_debounce_event.sv
// Bench for key_debounce_event: directed latency scenarios plus randomized key
// waveforms checked every cycle against a run-length reference model.
module tb_key_debounce_event;

  localparam int T1MS = 9;
  localparam int DEB  = 3;
  localparam int LONG = 20;
  localparam int MS_CLK    = T1MS + 1;
  localparam int DEB_RUN   = 2 + DEB * MS_CLK;   // consecutive samples to accept an edge
  localparam int LONG_HOLD = LONG * MS_CLK + 1;  // edges from (re)entering hold to Long_Sig

  logic CLK = 1'b0;
  logic RSTn;
  logic Key_In;
  logic Press_Sig, Release_Sig, Long_Sig, Key_State;

  key_debounce_event #(
    .T1MS        (16'd9),
    .DEBOUNCE_MS (11'd3),
    .LONG_MS     (11'd20)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .Key_In      (Key_In),
    .Press_Sig   (Press_Sig),
    .Release_Sig (Release_Sig),
    .Long_Sig    (Long_Sig),
    .Key_State   (Key_State)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the debounced level flips once the synchronised key has
  // disagreed with it for DEB_RUN consecutive samples; a long press fires when
  // the key has stayed down LONG_HOLD edges since the press or a rejected release.
  typedef struct {
    logic h1, h2;
    logic level;
    int   run;
    int   hold;
    logic long_done;
    logic p, r, l;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.h1 = 1'b1; m.h2 = 1'b1; m.level = 1'b0; m.run = 0; m.hold = 0;
    m.long_done = 1'b0; m.p = 1'b0; m.r = 1'b0; m.l = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, logic key);
    model_t n;
    logic   s;
    n = m;
    s = m.h2;
    n.h2 = m.h1;
    n.h1 = key;
    n.p = 1'b0; n.r = 1'b0; n.l = 1'b0;
    if (!m.level) begin
      if (!s) begin
        n.run = m.run + 1;
        if (n.run == DEB_RUN) begin
          n.p = 1'b1; n.level = 1'b1; n.run = 0; n.hold = 0; n.long_done = 1'b0;
        end
      end else begin
        n.run = 0;
      end
    end else if (s) begin
      n.run = m.run + 1;
      if (n.run == DEB_RUN) begin
        n.r = 1'b1; n.level = 1'b0; n.run = 0;
      end
    end else if (m.run > 0) begin
      n.run  = 0;
      n.hold = 0;
    end else begin
      n.hold = m.hold + 1;
      if (!m.long_done && n.hold == LONG_HOLD) begin
        n.l = 1'b1; n.long_done = 1'b1;
      end
    end
    return n;
  endfunction

  model_t m;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) m <= model_reset();
    else       m <= model_step(m, Key_In);
  end

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int unsigned press_cnt = 0, rel_cnt = 0, long_cnt = 0;
  int unsigned last_press_cyc = 0, last_rel_cyc = 0, last_long_cyc = 0;

  always @(negedge CLK) begin
    if (RSTn === 1'b1) begin
      check("model_press",   Press_Sig,   m.p);
      check("model_release", Release_Sig, m.r);
      check("model_long",    Long_Sig,    m.l);
      check("model_level",   Key_State,   m.level);
      check("one_strobe",    32'(($countones({Press_Sig, Release_Sig, Long_Sig}) <= 1)), 1);
      if (Press_Sig)   begin press_cnt++; last_press_cyc = cyc; end
      if (Release_Sig) begin rel_cnt++;   last_rel_cyc   = cyc; end
      if (Long_Sig)    begin long_cnt++;  last_long_cyc  = cyc; end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drives the key at a falling edge; e is the index of the first posedge sampling it.
  task automatic set_key(input logic v, output int unsigned e);
    @(negedge CLK);
    Key_In = v;
    e = cyc + 1;
  endtask

  int unsigned t0, t1, p0, r0, l0;

  initial begin
    Key_In = 1'b1;
    RSTn   = 1'b0;
    #1;
    check("reset_press",   Press_Sig,   0);
    check("reset_release", Release_Sig, 0);
    check("reset_long",    Long_Sig,    0);
    check("reset_level",   Key_State,   0);
    wait_cyc(3);
    RSTn = 1'b1;
    wait_cyc(5);

    // Clean press, then hold into long press, then clean release.
    p0 = press_cnt; r0 = rel_cnt; l0 = long_cnt;
    set_key(1'b0, t0);
    wait_cyc(60);
    check("s1_press_lat", last_press_cyc - t0, 33);
    check("s1_press_cnt", press_cnt - p0, 1);
    check("s1_no_other",  (rel_cnt - r0) + (long_cnt - l0), 0);
    check("s1_level",     Key_State, 1);
    wait_cyc(240);
    check("s3_long_lat",  last_long_cyc - t0, 234);
    check("s3_long_cnt",  long_cnt - l0, 1);
    set_key(1'b1, t1);
    wait_cyc(60);
    check("s3_rel_lat",   last_rel_cyc - t1, 33);
    check("s3_rel_cnt",   rel_cnt - r0, 1);
    check("s3_level",     Key_State, 0);
    check("s3_press_cnt", press_cnt - p0, 1);

    // Bounce reject, then a normal press proves the FSM is idle again.
    p0 = press_cnt; r0 = rel_cnt; l0 = long_cnt;
    set_key(1'b0, t0);
    wait_cyc(14);
    set_key(1'b1, t1);
    wait_cyc(60);
    check("s2_no_strobe", (press_cnt - p0) + (rel_cnt - r0) + (long_cnt - l0), 0);
    check("s2_level",     Key_State, 0);
    set_key(1'b0, t0);
    wait_cyc(60);
    check("s2_press_lat", last_press_cyc - t0, 33);

    // Release bounce after long press: no release, no second long press.
    wait_cyc(200);
    check("s4_long_cnt",  long_cnt - l0, 1);
    set_key(1'b1, t1);
    wait_cyc(11);
    set_key(1'b0, t1);
    wait_cyc(300);
    check("s4_no_release", rel_cnt - r0, 0);
    check("s4_long_once",  long_cnt - l0, 1);
    check("s4_level",      Key_State, 1);
    set_key(1'b1, t1);
    wait_cyc(60);
    check("s4_rel_lat",    last_rel_cyc - t1, 33);

    // Reset mid-debounce with the key kept down through reset release.
    p0 = press_cnt;
    set_key(1'b0, t0);
    repeat (21) @(posedge CLK);
    #1 RSTn = 1'b0;
    #1;
    check("s5_rst_press",   Press_Sig,   0);
    check("s5_rst_release", Release_Sig, 0);
    check("s5_rst_long",    Long_Sig,    0);
    check("s5_rst_level",   Key_State,   0);
    wait_cyc(3);
    RSTn = 1'b1;
    t0 = cyc + 1;
    wait_cyc(60);
    check("s5_press_cnt", press_cnt - p0, 1);
    check("s5_press_lat", last_press_cyc - t0, 33);
    set_key(1'b1, t1);
    wait_cyc(60);

    // Randomized key waveforms with occasional asynchronous resets.
    for (int seg = 0; seg < 90; seg++) begin
      int unsigned sel, len;
      sel = $urandom_range(0, 9);
      if (sel < 5)      len = $urandom_range(1, 40);
      else if (sel < 8) len = $urandom_range(30, 80);
      else              len = $urandom_range(200, 320);
      @(negedge CLK);
      Key_In = 1'($urandom_range(0, 1));
      wait_cyc(int'(len));
      if ($urandom_range(0, 24) == 0) begin
        #2 RSTn = 1'b0;
        wait_cyc(2);
        RSTn = 1'b1;
      end
    end
    Key_In = 1'b1;
    wait_cyc(80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
